// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch, data load/store) for one unified memory port.
// Optional build macro MEM_ARB_RR_EN selects round-robin tie-break instead of fixed D-over-IF.
module mem_port_arbiter #(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_a,
  output logic          mem_we,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_out,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  // Handshake: a requester raises req with a stable payload and holds both until the
  // cycle in which its ack pulses; req is only sampled while the FSM is in S_IDLE.

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wd_q, wd_d;
  logic          we_q, we_d;
  logic          gnt_q, gnt_d;   // 0 = IF, 1 = D
  logic          if_ack_q, if_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          pick_d;

`ifdef MEM_ARB_RR_EN
  logic          last_gnt_q, last_gnt_d;

  // On a tie, D wins only if IF was granted last.
  assign pick_d = d_req & (~if_req | ~last_gnt_q);
`else
  assign pick_d = d_req;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wd_d       = wd_q;
    we_d       = we_q;
    gnt_d      = gnt_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_gnt_d = last_gnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          state_d = S_ACCESS;
          gnt_d   = pick_d;
`ifdef MEM_ARB_RR_EN
          last_gnt_d = pick_d;
`endif
          if (pick_d) begin
            addr_d = d_addr;
            we_d   = d_we;
            wd_d   = d_wdata;
          end else begin
            addr_d = if_addr;
            we_d   = 1'b0;
          end
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        if (gnt_q) begin
          d_ack_d = 1'b1;
          if (!we_q) d_rdata_d = mem_out;
        end else begin
          if_ack_d   = 1'b1;
          if_rdata_d = mem_out;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wd_q       <= '0;
      we_q       <= 1'b0;
      gnt_q      <= 1'b0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
      last_gnt_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      we_q       <= we_d;
      gnt_q      <= gnt_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_gnt_q <= last_gnt_d;
`endif
    end
  end

  // Write enable is decoded from the state so an asynchronous reset drops it at once.
  assign mem_a     = addr_q;
  assign mem_wd    = wd_q;
  assign mem_we    = (state_q == S_ACCESS) & we_q;
  assign busy      = (state_q != S_IDLE);
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a memory model, requester driver tasks and an
// ack monitor that checks cycle and read data against an expected queue per port.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [15:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_out;
  logic        busy;
  logic [1:0]  dbg_state;

  logic [31:0] mem [0:65535];
  logic [63:0] exp_if_q[$];   // {ack cycle, rdata}
  logic [63:0] exp_d_q[$];
  int          cyc;
  int          total;
  int          bad;
  int          d_ack_seen;

  mem_port_arbiter #(.AW(16), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_out(mem_out),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory model
  assign mem_out = mem[mem_a];
  always @(posedge clk) if (mem_we) mem[mem_a] <= mem_wd;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // monitor
  always @(negedge clk) begin
    logic [63:0] e;
    if (if_ack || d_ack) check("ack_overlap", {63'd0, if_ack & d_ack}, 64'd0);
    if (if_ack) begin
      if (exp_if_q.size() == 0) begin
        total++; bad++;
        $display("FAIL if_unexpected_ack: got if_ack=1 want none (cycle %0d)", cyc);
      end else begin
        e = exp_if_q.pop_front();
        check("if_ack_cycle", 64'(cyc), {32'd0, e[63:32]});
        check("if_rdata", {32'd0, if_rdata}, {32'd0, e[31:0]});
      end
    end
    if (d_ack) begin
      d_ack_seen++;
      if (exp_d_q.size() == 0) begin
        total++; bad++;
        $display("FAIL d_unexpected_ack: got d_ack=1 want none (cycle %0d)", cyc);
      end else begin
        e = exp_d_q.pop_front();
        check("d_ack_cycle", 64'(cyc), {32'd0, e[63:32]});
        check("d_rdata", {32'd0, d_rdata}, {32'd0, e[31:0]});
      end
    end
  end

  // driver tasks: entered at a negedge, leave at the negedge after the last ack
  task automatic wait_ack(input logic is_d);
    int t;
    t = 0;
    while (!(is_d ? d_ack : if_ack) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!(is_d ? d_ack : if_ack)) begin
      total++; bad++;
      $display("FAIL %s_ack_timeout: got no ack want ack within 20 cycles", is_d ? "d" : "if");
    end
  endtask

  task automatic if_run(input logic [15:0] addr, input int n);
    for (int k = 0; k < n; k++) begin
      if_req  = 1'b1;
      if_addr = addr;
      wait_ack(1'b0);
      if_req = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic d_run(input logic we, input logic [15:0] addr, input logic [31:0] wd, input int n);
    for (int k = 0; k < n; k++) begin
      d_req   = 1'b1;
      d_we    = we;
      d_addr  = addr;
      d_wdata = wd;
      wait_ack(1'b1);
      d_req = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int dcount;
    total = 0; bad = 0; d_ack_seen = 0;
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 32'd0;
    mem[16'h0010] = 32'hDEADBEEF;
    mem[16'h0040] = 32'hA5A50001;
    mem[16'h0050] = 32'h5A5A0002;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_mem_we", {63'd0, mem_we}, 64'd0);
    check("rst_acks", {62'd0, if_ack, d_ack}, 64'd0);
    check("rst_rdata", {if_rdata, d_rdata}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // IF read
    s = cyc;
    exp_if_q.push_back({32'(s + 2), 32'hDEADBEEF});
    fork
      if_run(16'h0010, 1);
      begin
        @(negedge clk);
        check("if_access_mem_a", {48'd0, mem_a}, 64'h0010);
        check("if_access_busy", {63'd0, busy}, 64'd1);
        check("if_access_mem_we", {63'd0, mem_we}, 64'd0);
      end
    join

    // D store then load
    s = cyc;
    exp_d_q.push_back({32'(s + 2), 32'h0});
    fork
      d_run(1'b1, 16'h0020, 32'h12345678, 1);
      begin
        check("st_idle_mem_we", {63'd0, mem_we}, 64'd0);
        @(negedge clk);
        check("st_access_mem_we", {63'd0, mem_we}, 64'd1);
        check("st_access_mem_a", {48'd0, mem_a}, 64'h0020);
        check("st_access_mem_wd", {32'd0, mem_wd}, 64'h12345678);
        @(negedge clk);
        check("st_resp_mem_we", {63'd0, mem_we}, 64'd0);
      end
    join
    check("st_mem_content", {32'd0, mem[16'h0020]}, 64'h12345678);
    s = cyc;
    exp_d_q.push_back({32'(s + 2), 32'h12345678});
    d_run(1'b0, 16'h0020, 32'h0, 1);

    // reset mid-transaction clears outputs at once
    if_req = 1'b1; if_addr = 16'h0040;
    @(negedge clk);
    rst = 1'b1;
    if_req = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_state", {62'd0, dbg_state}, 64'd0);
    check("midrst_acks", {62'd0, if_ack, d_ack}, 64'd0);
    check("midrst_rdata", {if_rdata, d_rdata}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // contention: D wins the first tie, IF served next
    s = cyc;
    exp_d_q.push_back({32'(s + 2), 32'hA5A50001});
    exp_if_q.push_back({32'(s + 5), 32'h5A5A0002});
    fork
      d_run(1'b0, 16'h0040, 32'h0, 1);
      if_run(16'h0050, 1);
    join

    // reset during ACCESS of a store aborts it
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0030; d_wdata = 32'hCAFEF00D;
    @(negedge clk);
    check("abort_access_mem_we", {63'd0, mem_we}, 64'd1);
    dcount = d_ack_seen;
    rst = 1'b1;
    d_req = 1'b0;
    #1;
    check("abort_mem_we", {63'd0, mem_we}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_ack", 64'(d_ack_seen), 64'(dcount));
    check("abort_mem_content", {32'd0, mem[16'h0030]}, 64'h0);
    check("abort_state", {62'd0, dbg_state}, 64'd0);

    // both requesters held and re-raised after each ack
    s = cyc;
`ifdef MEM_ARB_RR_EN
    exp_d_q.push_back({32'(s + 2), 32'hA5A50001});
    exp_if_q.push_back({32'(s + 5), 32'h5A5A0002});
    exp_d_q.push_back({32'(s + 8), 32'hA5A50001});
    exp_if_q.push_back({32'(s + 11), 32'h5A5A0002});
    fork
      d_run(1'b0, 16'h0040, 32'h0, 2);
      if_run(16'h0050, 2);
    join
`else
    exp_d_q.push_back({32'(s + 2), 32'hA5A50001});
    exp_d_q.push_back({32'(s + 5), 32'hA5A50001});
    exp_d_q.push_back({32'(s + 8), 32'hA5A50001});
    exp_if_q.push_back({32'(s + 11), 32'h5A5A0002});
    fork
      d_run(1'b0, 16'h0040, 32'h0, 3);
      if_run(16'h0050, 1);
    join
`endif

    repeat (2) @(negedge clk);
    check("if_queue_drained", 64'(exp_if_q.size()), 64'd0);
    check("d_queue_drained", 64'(exp_d_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
